// File: rtl/qproc_in_port_pkg.sv
// Shared types and limits for the input-port capture block and its FIFOs.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Timestamp support is controlled by the QPROC_IN_PORT_TSTAMP_EN macro.
package qproc_in_port_pkg;

  localparam int MAX_IN_PORT_QTY = 16;
  localparam int MAX_PAW         = 4;
  localparam int MAX_DW          = 64;
  localparam int TS_W            = 32;

  // CPU read request, with the address widened to the largest port count
  typedef struct packed {
    logic               re;
    logic               pop;
    logic [MAX_PAW-1:0] addr;
  } IN_PORT_REQ;

  // Registered read response
  typedef struct packed {
    logic [MAX_DW-1:0] dt;
    logic              vld;
`ifdef QPROC_IN_PORT_TSTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } IN_PORT_RSP;

  // True when the requested port exists in this configuration
  function automatic logic addr_in_range(input logic [MAX_PAW-1:0] a, input int qty);
    return int'(a) < qty;
  endfunction

endpackage

// File: rtl/qproc_port_fifo.sv
// Per-port FIFO: storage, wrapping pointers, count, push/pop/clear logic.
// Latency: head word visible on rdat_o one cycle after the push.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is dropped and flagged on drop_o.
module qproc_port_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdat_i,
  output logic [W-1:0] rdat_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign rdat_o  = mem_q[rd_ptr_q];

  // Accept/drop decisions and next pointer/count; a pop frees room for a same-cycle push
  always_comb begin
    pop_ok   = pop_i && !empty_o && !clr_i;
    push_ok  = push_i && !clr_i && (!full || pop_ok);
    drop_o   = push_i && !clr_i && full && !pop_ok;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset because the count gates every read
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdat_i;
  end

endmodule

// File: rtl/qproc_in_port_ctrl.sv
// Captures external input ports into per-port FIFOs and latest-value registers for CPU reads.
// Latency: read request at cycle N returns dt_o/dt_vld_o at N+1.
// Backpressure: none on ports (overflow drops the word, sets sticky ovf_o); CPU misses show as dt_vld_o=0.
// Optional timestamp capture is enabled by defining QPROC_IN_PORT_TSTAMP_EN.
module qproc_in_port_ctrl
  import qproc_in_port_pkg::*;
#(
  parameter int IN_PORT_QTY = 4,
  parameter int DW          = 64,
  parameter int DEPTH       = 8,
  parameter int PAW         = 2
) (
  input  logic                            c_clk_i,
  input  logic                            c_rst_i,
  input  logic [IN_PORT_QTY-1:0][DW-1:0]  port_dt_i,
  input  logic [IN_PORT_QTY-1:0]          port_vld_i,
  input  logic                            re_i,
  input  logic [PAW-1:0]                  addr_i,
  input  logic                            pop_i,
  input  logic                            clr_i,
`ifdef QPROC_IN_PORT_TSTAMP_EN
  input  logic [TS_W-1:0]                 time_i,
  output logic [TS_W-1:0]                 ts_o,
`endif
  output logic [DW-1:0]                   dt_o,
  output logic                            dt_vld_o,
  output logic [IN_PORT_QTY-1:0]          empty_o,
  output logic [IN_PORT_QTY-1:0]          ovf_o
);

`ifdef QPROC_IN_PORT_TSTAMP_EN
  localparam int FW = DW + TS_W;
`else
  localparam int FW = DW;
`endif

  IN_PORT_REQ                      req;
  logic                            addr_ok;
  logic [IN_PORT_QTY-1:0][FW-1:0]  wdat;
  logic [IN_PORT_QTY-1:0][FW-1:0]  head;
  logic [IN_PORT_QTY-1:0]          pop_req;
  logic [IN_PORT_QTY-1:0]          drop;

  logic [IN_PORT_QTY-1:0][FW-1:0]  last_q, last_d;
  logic [IN_PORT_QTY-1:0]          seen_q, seen_d;
  logic [IN_PORT_QTY-1:0]          ovf_q, ovf_d;
  IN_PORT_RSP                      rsp_q, rsp_d;

  logic [FW-1:0]                   sel_last;
  logic [FW-1:0]                   sel_head;
  logic                            sel_seen;
  logic                            sel_empty;

  assign req     = '{re: re_i, pop: pop_i, addr: MAX_PAW'(addr_i)};
  assign addr_ok = addr_in_range(req.addr, IN_PORT_QTY);

  // Word stored per port: data, with the capture time in the upper bits when enabled
  always_comb begin
    wdat = '0;
    for (int k = 0; k < IN_PORT_QTY; k++) begin
`ifdef QPROC_IN_PORT_TSTAMP_EN
      wdat[k] = {time_i, port_dt_i[k]};
`else
      wdat[k] = port_dt_i[k];
`endif
    end
  end

  // Pop strobe only to the addressed FIFO; the FIFO itself ignores it during clr_i
  always_comb begin
    pop_req = '0;
    for (int k = 0; k < IN_PORT_QTY; k++) begin
      pop_req[k] = req.re && req.pop && (req.addr == MAX_PAW'(k));
    end
  end

  for (genvar g = 0; g < IN_PORT_QTY; g++) begin : g_fifo
    qproc_port_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i   (c_clk_i),
      .rst_i   (c_rst_i),
      .clr_i   (clr_i),
      .push_i  (port_vld_i[g]),
      .pop_i   (pop_req[g]),
      .wdat_i  (wdat[g]),
      .rdat_o  (head[g]),
      .empty_o (empty_o[g]),
      .drop_o  (drop[g])
    );
  end

  // Latest value follows every strobe, even under clr_i; seen/ovf are cleared by clr_i
  always_comb begin
    last_d = last_q;
    for (int k = 0; k < IN_PORT_QTY; k++) begin
      if (port_vld_i[k]) last_d[k] = wdat[k];
    end
    seen_d = clr_i ? '0 : (seen_q | port_vld_i);
    ovf_d  = clr_i ? '0 : (ovf_q | drop);
  end

  // Read mux: select the addressed port, then build the response; misses hold dt
  always_comb begin
    sel_last  = '0;
    sel_head  = '0;
    sel_seen  = 1'b0;
    sel_empty = 1'b1;
    for (int k = 0; k < IN_PORT_QTY; k++) begin
      if (req.addr == MAX_PAW'(k)) begin
        sel_last  = last_q[k];
        sel_head  = head[k];
        sel_seen  = seen_q[k];
        sel_empty = empty_o[k];
      end
    end
    rsp_d     = rsp_q;
    rsp_d.vld = 1'b0;
    if (req.re && !clr_i && addr_ok) begin
      if (!req.pop) begin
        rsp_d.dt  = MAX_DW'(sel_last[DW-1:0]);
        rsp_d.vld = sel_seen;
`ifdef QPROC_IN_PORT_TSTAMP_EN
        rsp_d.ts  = sel_last[FW-1:DW];
`endif
      end else if (!sel_empty) begin
        rsp_d.dt  = MAX_DW'(sel_head[DW-1:0]);
        rsp_d.vld = 1'b1;
`ifdef QPROC_IN_PORT_TSTAMP_EN
        rsp_d.ts  = sel_head[FW-1:DW];
`endif
      end
    end
  end

  // State and output registers; reset discards any in-flight read
  always_ff @(posedge c_clk_i) begin
    if (c_rst_i) begin
      last_q <= '0;
      seen_q <= '0;
      ovf_q  <= '0;
      rsp_q  <= '0;
    end else begin
      last_q <= last_d;
      seen_q <= seen_d;
      ovf_q  <= ovf_d;
      rsp_q  <= rsp_d;
    end
  end

  assign dt_o     = rsp_q.dt[DW-1:0];
  assign dt_vld_o = rsp_q.vld;
  assign ovf_o    = ovf_q;
`ifdef QPROC_IN_PORT_TSTAMP_EN
  assign ts_o     = rsp_q.ts;
`endif

endmodule

// File: tb/tb_qproc_in_port_ctrl.sv
// Directed bench for qproc_in_port_ctrl with a behavioural model and response scoreboard.
// Latency: checks each read result one cycle after the request.
// Backpressure: exercises overflow, full push+pop, clear and reset interactions.
module tb_qproc_in_port_ctrl;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int PAW   = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0][DW-1:0] port_dt;
  logic [N-1:0]         port_vld;
  logic                 re;
  logic [PAW-1:0]       addr;
  logic                 pop;
  logic                 clr;
  logic [DW-1:0]        dt;
  logic                 dt_vld;
  logic [N-1:0]         empty;
  logic [N-1:0]         ovf;
`ifdef QPROC_IN_PORT_TSTAMP_EN
  logic [31:0]          tb_time = '0;
  logic [31:0]          ts;
  always @(posedge clk) tb_time <= tb_time + 32'd1;
`endif

  always #5 clk = ~clk;

  qproc_in_port_ctrl #(
    .IN_PORT_QTY (N),
    .DW          (DW),
    .DEPTH       (DEPTH),
    .PAW         (PAW)
  ) dut (
    .c_clk_i    (clk),
    .c_rst_i    (rst),
    .port_dt_i  (port_dt),
    .port_vld_i (port_vld),
    .re_i       (re),
    .addr_i     (addr),
    .pop_i      (pop),
    .clr_i      (clr),
`ifdef QPROC_IN_PORT_TSTAMP_EN
    .time_i     (tb_time),
    .ts_o       (ts),
`endif
    .dt_o       (dt),
    .dt_vld_o   (dt_vld),
    .empty_o    (empty),
    .ovf_o      (ovf)
  );

  typedef struct packed {
    logic [DW-1:0] dt;
    logic          vld;
  } exp_t;

  // Behavioural model
  logic [DW-1:0] mq [N][$];
  logic [DW-1:0] mlast [N];
  logic          mseen [N];
  logic          movf  [N];
  logic [DW-1:0] mheld;
  exp_t          sb [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      mlast[k] = '0;
      mseen[k] = 1'b0;
      movf[k]  = 1'b0;
    end
    mheld = '0;
  endtask

  // One clock cycle: predict, drive, clock, compare
  task automatic cyc(input logic r, input logic c, input logic [N-1:0] v,
                     input logic [N-1:0][DW-1:0] wd, input logic rq,
                     input logic p, input logic [PAW-1:0] a_in);
    exp_t          e;
    exp_t          got;
    int            a;
    logic          popped;
    logic [DW-1:0] tmp;
    logic [N-1:0]  ee;
    logic [N-1:0]  eo;
    a      = int'(a_in);
    popped = 1'b0;
    if (r) begin
      model_reset();
      e = '0;
    end else begin
      e.dt  = mheld;
      e.vld = 1'b0;
      if (rq && !c && a < N) begin
        if (!p) begin
          e.dt  = mlast[a];
          e.vld = mseen[a];
        end else if (mq[a].size() > 0) begin
          e.dt   = mq[a][0];
          e.vld  = 1'b1;
          popped = 1'b1;
        end
      end
      if (popped) tmp = mq[a].pop_front();
      for (int k = 0; k < N; k++) if (v[k]) mlast[k] = wd[k];
      if (c) begin
        for (int k = 0; k < N; k++) begin
          mq[k].delete();
          mseen[k] = 1'b0;
          movf[k]  = 1'b0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (v[k]) begin
            mseen[k] = 1'b1;
            if (mq[k].size() < DEPTH) mq[k].push_back(wd[k]);
            else movf[k] = 1'b1;
          end
        end
      end
    end
    mheld = e.dt;
    sb.push_back(e);

    rst = r; clr = c; port_vld = v; port_dt = wd; re = rq; pop = p; addr = a_in;
    @(posedge clk);
    #1;
    rst = 1'b0; clr = 1'b0; port_vld = '0; re = 1'b0; pop = 1'b0;

    for (int k = 0; k < N; k++) begin
      ee[k] = (mq[k].size() == 0);
      eo[k] = movf[k];
    end
    got = sb.pop_front();
    check("dt_o",     dt,                     got.dt);
    check("dt_vld_o", {63'b0, dt_vld},        {63'b0, got.vld});
    check("empty_o",  {{(DW-N){1'b0}}, empty}, {{(DW-N){1'b0}}, ee});
    check("ovf_o",    {{(DW-N){1'b0}}, ovf},   {{(DW-N){1'b0}}, eo});
  endtask

  task automatic wr(input int k, input logic [DW-1:0] d);
    logic [N-1:0][DW-1:0] wd;
    wd    = '0;
    wd[k] = d;
    cyc(1'b0, 1'b0, N'(1) << k, wd, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int a, input logic p);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, p, PAW'(a));
  endtask

  initial begin
    logic [N-1:0][DW-1:0] wd;
    rst = 1'b1; clr = 1'b0; port_vld = '0; port_dt = '0;
    re = 1'b0; pop = 1'b0; addr = '0;
    model_reset();

    // Reset state
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);

    // Latest-value peek
    wr(1, 64'hAAAA);
    rd(1, 1'b0);
    rd(0, 1'b0);

    // Pop in order, then underflow holds dt_o
    for (int i = 1; i <= 3; i++) wr(2, DW'(i));
    repeat (4) rd(2, 1'b1);

    // Overflow on port 0
    for (int i = 0; i <= DEPTH; i++) wr(0, DW'(i));
    repeat (DEPTH) rd(0, 1'b1);
    rd(0, 1'b0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) wr(3, DW'(32'h300 + i));
    wd = '0;
    wd[3] = 64'h3FF;
    cyc(1'b0, 1'b0, 4'b1000, wd, 1'b1, 1'b1, 3'd3);
    repeat (DEPTH + 1) rd(3, 1'b1);

    // Clear with data and overflow on port 1
    for (int i = 0; i <= DEPTH; i++) wr(1, DW'(32'h100 + i));
    cyc(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, '0);
    rd(1, 1'b1);

    // Clear with same-cycle write and read
    wd = '0;
    wd[0] = 64'hBEEF;
    cyc(1'b0, 1'b1, 4'b0001, wd, 1'b1, 1'b0, 3'd0);
    rd(0, 1'b0);

    // Out-of-range address
    rd(5, 1'b0);
    rd(5, 1'b1);

    // Push into empty FIFO while popping it: miss, then the word is there
    wd = '0;
    wd[2] = 64'h55;
    cyc(1'b0, 1'b0, 4'b0100, wd, 1'b1, 1'b1, 3'd2);
    rd(2, 1'b1);

    // Reset right after a pop, with a further pop request held during reset
    wr(2, 64'h77);
    rd(2, 1'b1);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 3'd2);
    rd(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
